// File: rtl/fix_mac_accum_if.sv
// ----------------------------------------------------------------------------
// fix_mac_accum_if
// Bundles the product input stream, the abort strobe and the result output
// stream of fix_mac_accum.
//
// Handshake rules (both streams): a transfer happens on a rising clock edge
// where valid and ready are both 1. The sender keeps data and valid stable
// until that transfer. Ready may depend on state only, never on valid.
//
// Signals
//   prod_i        master->slave  signed Q16.16 product
//   prod_valid_i  master->slave  prod_i valid
//   prod_last_i   master->slave  prod_i is the final term of its group
//   prod_ready_o  slave->master  block accepts a product this cycle
//   clear_i       master->slave  synchronous abort of group and result
//   sum_o         slave->master  group result, Q16.16
//   sum_valid_o   slave->master  sum_o valid
//   sum_ready_i   master->slave  downstream takes sum_o
//   term_cnt_o    slave->master  terms in the current or held group
//   ovf_o         slave->master  held result was clipped
//   state_o       slave->master  debug view of the control state
// ----------------------------------------------------------------------------
interface fix_mac_accum_if #(
    parameter int DATA_W    = 32,
    parameter int MAX_TERMS = 8
);
    localparam int CNT_W = $clog2(MAX_TERMS + 1);

    logic [DATA_W-1:0] prod_i;
    logic              prod_valid_i;
    logic              prod_last_i;
    logic              prod_ready_o;
    logic              clear_i;
    logic [DATA_W-1:0] sum_o;
    logic              sum_valid_o;
    logic              sum_ready_i;
    logic [CNT_W-1:0]  term_cnt_o;
    logic              ovf_o;
    logic [1:0]        state_o;

    modport master (
        output prod_i, prod_valid_i, prod_last_i, clear_i, sum_ready_i,
        input  prod_ready_o, sum_o, sum_valid_o, term_cnt_o, ovf_o, state_o
    );

    modport slave (
        input  prod_i, prod_valid_i, prod_last_i, clear_i, sum_ready_i,
        output prod_ready_o, sum_o, sum_valid_o, term_cnt_o, ovf_o, state_o
    );
endinterface

// File: rtl/fix_mac_accum.sv
// ----------------------------------------------------------------------------
// fix_mac_accum
// Collects signed Q16.16 products one per cycle into a guard-extended
// accumulator and presents one Q16.16 result per group on a valid/ready
// output. A group ends on prod_last_i or when MAX_TERMS terms are in.
//
// Ports
//   clk_i    rising-edge clock
//   rst_n_i  asynchronous active-low reset
//   bus      fix_mac_accum_if.slave (product stream, clear, result stream)
//
// Optional feature macro: FIXACC_SATURATE_EN
//   defined   : result clips to 0x80000000..0x7FFFFFFF, ovf_o flags a clip
//   undefined : result is the low DATA_W bits of the accumulator, ovf_o = 0
// ----------------------------------------------------------------------------
module fix_mac_accum #(
    parameter int DATA_W    = 32,
    parameter int GUARD_W   = 8,
    parameter int MAX_TERMS = 8
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    fix_mac_accum_if.slave  bus
);
    localparam int ACC_W = DATA_W + GUARD_W;
    localparam int CNT_W = $clog2(MAX_TERMS + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_OUT   = 2'd2;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TERMS);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    logic [1:0]        r_state;
    logic [ACC_W-1:0]  r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_sum;
    logic              r_sum_valid;
    logic              r_ovf;

    logic              w_ready;
    logic              w_accept;
    logic [ACC_W-1:0]  w_prod_ext;
    logic [ACC_W-1:0]  w_acc_next;
    logic [CNT_W-1:0]  w_cnt_next;
    logic              w_group_end;
    logic [DATA_W-1:0] w_sum_final;
    logic              w_ovf_final;

    assign w_ready    = (r_state != S_OUT);
    assign w_accept   = bus.prod_valid_i && w_ready;
    assign w_prod_ext = {{GUARD_W{bus.prod_i[DATA_W-1]}}, bus.prod_i};

    // The first term of a group loads rather than adds.
    assign w_acc_next  = ((r_state == S_IDLE) ? '0 : r_acc) + w_prod_ext;
    assign w_cnt_next  = ((r_state == S_IDLE) ? '0 : r_cnt) + ONE_CNT;
    assign w_group_end = bus.prod_last_i || (w_cnt_next == MAX_CNT);

`ifdef FIXACC_SATURATE_EN
    logic w_in_range;
    // In range when every bit from the guard MSB down to the Q16.16 sign bit
    // agrees, i.e. the value fits in DATA_W signed bits.
    assign w_in_range = (&w_acc_next[ACC_W-1:DATA_W-1]) ||
                        ~(|w_acc_next[ACC_W-1:DATA_W-1]);

    always_comb begin
        w_sum_final = w_acc_next[DATA_W-1:0];
        w_ovf_final = 1'b0;
        if (!w_in_range) begin
            w_ovf_final = 1'b1;
            if (w_acc_next[ACC_W-1])
                w_sum_final = {1'b1, {(DATA_W-1){1'b0}}};
            else
                w_sum_final = {1'b0, {(DATA_W-1){1'b1}}};
        end
    end
`else
    assign w_sum_final = w_acc_next[DATA_W-1:0];
    assign w_ovf_final = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_sum       <= '0;
            r_sum_valid <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (bus.clear_i) begin
            // Abort wins over everything, including a product in this cycle.
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_sum_valid <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_ACCUM: begin
                    if (w_accept) begin
                        r_acc <= w_acc_next;
                        r_cnt <= w_cnt_next;
                        if (w_group_end) begin
                            r_sum       <= w_sum_final;
                            r_ovf       <= w_ovf_final;
                            r_sum_valid <= 1'b1;
                            r_state     <= S_OUT;
                        end else begin
                            r_state <= S_ACCUM;
                        end
                    end
                end
                S_OUT: begin
                    if (bus.sum_ready_i) begin
                        r_state     <= S_IDLE;
                        r_acc       <= '0;
                        r_cnt       <= '0;
                        r_sum_valid <= 1'b0;
                        r_ovf       <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_acc   <= '0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.prod_ready_o = w_ready;
    assign bus.sum_o        = r_sum;
    assign bus.sum_valid_o  = r_sum_valid;
    assign bus.term_cnt_o   = r_cnt;
    assign bus.ovf_o        = r_ovf;
    assign bus.state_o      = r_state;
endmodule

// File: tb/tb_fix_mac_accum.sv
// ----------------------------------------------------------------------------
// tb_fix_mac_accum
// Directed and randomized groups against a plain-arithmetic reference of the
// group sum. Honours FIXACC_SATURATE_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_fix_mac_accum;
    localparam int DATA_W    = 32;
    localparam int GUARD_W   = 8;
    localparam int MAX_TERMS = 8;

    logic clk_i;
    logic rst_n_i;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] grp_q[$];

    fix_mac_accum_if #(.DATA_W(DATA_W), .MAX_TERMS(MAX_TERMS)) bus ();

    fix_mac_accum #(
        .DATA_W   (DATA_W),
        .GUARD_W  (GUARD_W),
        .MAX_TERMS(MAX_TERMS)
    ) dut (
        .clk_i  (clk_i),
        .rst_n_i(rst_n_i),
        .bus    (bus)
    );

    // clock
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer sum of the group, then reduced to Q16.16.
    task automatic model_sum(output logic [DATA_W-1:0] s, output logic o);
        longint acc;
        longint lo;
        longint hi;
        acc = 0;
        lo  = -(64'sd1 <<< (DATA_W - 1));
        hi  = (64'sd1 <<< (DATA_W - 1)) - 1;
        foreach (grp_q[i]) acc += longint'($signed(grp_q[i]));
        s = acc[DATA_W-1:0];
        o = 1'b0;
`ifdef FIXACC_SATURATE_EN
        if (acc > hi) begin
            s = hi[DATA_W-1:0];
            o = 1'b1;
        end else if (acc < lo) begin
            s = lo[DATA_W-1:0];
            o = 1'b1;
        end
`else
        if (lo > hi) s = '0;
`endif
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Sends grp_q as one group, then holds the result for `hold` cycles.
    task automatic send_group(input bit use_last, input int gap_max, input int hold);
        logic [DATA_W-1:0] exp_sum;
        logic              exp_ovf;
        int                n;
        n = grp_q.size();
        model_sum(exp_sum, exp_ovf);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(gap_max, 0)) begin
                bus.prod_valid_i = 1'b0;
                tick();
                chk("gap_cnt", bus.term_cnt_o, i);
            end
            bus.prod_i       = grp_q[i];
            bus.prod_valid_i = 1'b1;
            bus.prod_last_i  = use_last && (i == n - 1);
            chk("prod_ready", bus.prod_ready_o, 1);
            tick();
        end
        bus.prod_valid_i = 1'b0;
        bus.prod_last_i  = 1'b0;
        chk("sum_valid", bus.sum_valid_o, 1);
        chk("sum", bus.sum_o, exp_sum);
        chk("term_cnt", bus.term_cnt_o, n);
        chk("ovf", bus.ovf_o, exp_ovf);
        chk("ready_out", bus.prod_ready_o, 0);
        if (hold > 0) begin
            bus.sum_ready_i  = 1'b0;
            bus.prod_valid_i = 1'b1;
            repeat (hold) begin
                tick();
                chk("hold_sum", bus.sum_o, exp_sum);
                chk("hold_valid", bus.sum_valid_o, 1);
                chk("hold_ready", bus.prod_ready_o, 0);
                chk("hold_cnt", bus.term_cnt_o, n);
            end
            bus.prod_valid_i = 1'b0;
        end
        bus.sum_ready_i = 1'b1;
        tick();
        chk("post_ready", bus.prod_ready_o, 1);
        chk("post_valid", bus.sum_valid_o, 0);
        chk("post_cnt", bus.term_cnt_o, 0);
    endtask

    initial begin
        int n;
        bit ul;
        rst_n_i          = 1'b0;
        bus.prod_i       = '0;
        bus.prod_valid_i = 1'b0;
        bus.prod_last_i  = 1'b0;
        bus.clear_i      = 1'b0;
        bus.sum_ready_i  = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        tick();

        // reset values
        chk("rst_ready", bus.prod_ready_o, 1);
        chk("rst_sum", bus.sum_o, 0);
        chk("rst_valid", bus.sum_valid_o, 0);
        chk("rst_cnt", bus.term_cnt_o, 0);
        chk("rst_ovf", bus.ovf_o, 0);

        // 2.5 + 2.5 - 2.5
        grp_q = '{32'h00028000, 32'h00028000, 32'hFFFD8000};
        send_group(1'b1, 0, 0);
        // single negative term
        grp_q = '{32'hFFFFFD71};
        send_group(1'b1, 0, 0);
        // positive and negative overflow cases
        grp_q = '{32'h7FFF0000, 32'h00020000};
        send_group(1'b1, 0, 0);
        grp_q = '{32'h80000000, 32'hFFFF0000};
        send_group(1'b1, 0, 0);
        // forced end at MAX_TERMS, then backpressure for 3 cycles
        grp_q = {};
        repeat (MAX_TERMS) grp_q.push_back(32'h00010000);
        send_group(1'b0, 0, 3);
        // next group starts from zero
        grp_q = '{32'h00000001};
        send_group(1'b1, 0, 0);

        // clear mid-group with a product in the same cycle
        bus.prod_valid_i = 1'b1;
        bus.prod_i       = 32'h00050000;
        tick();
        tick();
        bus.clear_i = 1'b1;
        tick();
        bus.clear_i      = 1'b0;
        bus.prod_valid_i = 1'b0;
        chk("clr_valid", bus.sum_valid_o, 0);
        chk("clr_cnt", bus.term_cnt_o, 0);
        chk("clr_ready", bus.prod_ready_o, 1);
        grp_q = '{32'h00008000};
        send_group(1'b1, 0, 0);

        // clear while a result is held
        grp_q = '{32'h00001234};
        bus.prod_i       = grp_q[0];
        bus.prod_valid_i = 1'b1;
        bus.prod_last_i  = 1'b1;
        bus.sum_ready_i  = 1'b0;
        tick();
        bus.prod_valid_i = 1'b0;
        bus.prod_last_i  = 1'b0;
        chk("clrout_pre", bus.sum_valid_o, 1);
        bus.clear_i = 1'b1;
        tick();
        bus.clear_i     = 1'b0;
        bus.sum_ready_i = 1'b1;
        chk("clrout_valid", bus.sum_valid_o, 0);
        chk("clrout_ovf", bus.ovf_o, 0);
        chk("clrout_ready", bus.prod_ready_o, 1);

        // asynchronous reset in the middle of a group
        bus.prod_i       = 32'h00030000;
        bus.prod_valid_i = 1'b1;
        tick();
        tick();
        chk("ar_pre_cnt", bus.term_cnt_o, 2);
        #2;
        rst_n_i = 1'b0;
        #1;
        chk("ar_sum", bus.sum_o, 0);
        chk("ar_valid", bus.sum_valid_o, 0);
        chk("ar_cnt", bus.term_cnt_o, 0);
        chk("ar_ready", bus.prod_ready_o, 1);
        chk("ar_ovf", bus.ovf_o, 0);
        bus.prod_valid_i = 1'b0;
        @(negedge clk_i);
        rst_n_i = 1'b1;
        tick();

        // randomized groups
        for (int g = 0; g < 40; g++) begin
            n = $urandom_range(MAX_TERMS, 1);
            ul = (n < MAX_TERMS) ? 1'b1 : 1'($urandom_range(1, 0));
            grp_q = {};
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(3, 0) == 0)
                    grp_q.push_back($urandom());
                else
                    grp_q.push_back(32'($signed($urandom_range(32'h000FFFFF, 0)) - 32'sh00080000));
            end
            send_group(ul, 2, $urandom_range(2, 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fix_mac_accum.md
# fix_mac_accum

Sequential multiply-accumulate collector for the IIR datapath. It sits directly downstream of the fixed-point multiplier and consumes its signed Q16.16 products one per cycle. Each group of products (one filter output's tap terms) is summed in a guard-extended accumulator. One Q16.16 result per group is presented on a valid/ready output to the filter state-update stage.

## Interface
- DATA_W, 32: product and result width, signed two's complement Q16.16
- GUARD_W, 8: accumulator guard bits; accumulator width is DATA_W+GUARD_W
- MAX_TERMS, 8: maximum products per group; forces group end when reached
- clk_i  in  1  single clock, rising edge
- rst_n_i  in  1  reset, asynchronous assert, active low
- prod_i  in  DATA_W  signed Q16.16 product from the multiplier
- prod_valid_i  in  1  prod_i is valid this cycle
- prod_last_i  in  1  qualifies prod_i as the final term of the group
- prod_ready_o  out  1  block accepts a product this cycle
- clear_i  in  1  synchronous abort; discards the group and any pending result
- sum_o  out  DATA_W  group result, Q16.16
- sum_valid_o  out  1  sum_o is valid
- sum_ready_i  in  1  downstream accepts sum_o
- term_cnt_o  out  $clog2(MAX_TERMS+1)  number of terms in the current or held group
- ovf_o  out  1  held result was clipped; valid with sum_valid_o

## Operation
- States:
  - IDLE: empty group.
  - ACCUM: at least one term accepted.
  - OUT: result held.
- A product is accepted when prod_valid_i && prod_ready_o. prod_ready_o = 1 in IDLE and ACCUM, and 0 in OUT.
- Accept in IDLE: acc <= sext(prod_i), term count <= 1, next state ACCUM. If the group ends on this accept, next state is OUT.
- Accept in ACCUM: acc <= acc + sext(prod_i), term count +1.
- Group end: the accept has prod_last_i = 1, or the new term count equals MAX_TERMS.
  - On group end: sum_o <= final(acc_next), ovf_o registered, next state OUT.
- OUT: sum_o, ovf_o and term_cnt_o are held stable. On sum_ready_i = 1: next state IDLE, acc and count cleared.
- clear_i has top priority in every state. On clear_i: next state IDLE, acc = 0, count = 0, sum_valid_o = 0, ovf_o = 0. A product presented in the same cycle is dropped.
- prod_valid_i = 0 in ACCUM: hold, no change.
- Arithmetic:
  - Sign-extend DATA_W to DATA_W+GUARD_W before adding.
  - The accumulator wraps only at DATA_W+GUARD_W bits. With the default MAX_TERMS of 8, this cannot occur.
  - final() reduces to DATA_W per Configuration.

## Timing
- Reset values: prod_ready_o = 1, sum_o = 0, sum_valid_o = 0, term_cnt_o = 0, ovf_o = 0, state IDLE, acc = 0.
- Latency: sum_valid_o rises on the clock edge after the last-term accept.
- Throughput:
  - One product per cycle within a group.
  - The cycle after the output handshake is IDLE with prod_ready_o = 1. No extra bubble beyond the OUT cycle(s).
- Backpressure: while sum_ready_i = 0 in OUT, all outputs are frozen and prod_ready_o = 0.
- Asynchronous reset mid-group or mid-OUT: all state returns to reset values immediately; the partial group is lost.
- All outputs are registered except prod_ready_o, which is a decode of the state register.

## Configuration
- FIXACC_SATURATE_EN defined:
  - final() clips to the range 0x80000000..0x7FFFFFFF.
  - ovf_o = 1 when clipping occurred.
- Not defined:
  - final() takes acc[DATA_W-1:0] (two's complement wrap).
  - ovf_o is tied to 0.

## Test plan
- Reset, then three products with last on the third: 0x00028000 (2.5), 0x00028000, 0xFFFD8000 (-2.5) -> one cycle later sum_o = 0x00028000, term_cnt_o = 3, ovf_o = 0.
- Single product 0xFFFFFD71 (-0.01) with last -> sum_o = 0xFFFFFD71, sum_valid_o high on the next edge.
- Saturation with macro defined:
  - 0x7FFF0000 + 0x00020000 -> sum_o = 0x7FFFFFFF, ovf_o = 1.
  - 0x80000000 + 0xFFFF0000 -> 0x80000000, ovf_o = 1.
  - Without the macro, the first case gives 0x80010000 with ovf_o = 0.
- Eight products of 0x00010000 with prod_last_i never asserted -> forced end: sum_o = 0x00080000, term_cnt_o = 8.
- Hold sum_ready_i low 3 cycles in OUT -> sum_o stable, prod_ready_o = 0. Assert it -> prod_ready_o = 1 the next cycle and the next group starts from acc = 0.
- Mid-group clear_i with a valid product in the same cycle -> no result produced. The next group of 0x00008000 with last -> sum_o = 0x00008000.
- rst_n_i pulsed low between clock edges during ACCUM -> outputs at reset values immediately.
